sqrt_job_sequencer: RTL and testbench

Front-end and back-end wrapper for the square-root core: buffers incoming 32-bit operands in a small tagged request FIFO, issues them one at a time to the core via its `start`/`in` pins, and waits for the core's `done`. It then returns each result with its tag on a valid/ready response channel. It sits between the operand producer and the sqrt core and removes all core-protocol knowledge from the producer.

---
 rtl/sqrt_job_sequencer.sv | 177 +++++++++++++++++
 tb/tb_sqrt_job_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sqrt_job_sequencer.sv
// sqrt_job_sequencer: request FIFO + issue/wait/respond sequencer for the
// square-root core. Operands are queued with a tag, issued one at a time on
// sq_start/sq_in, and each result is returned in order on a valid/ready
// response channel.
// Optional feature: define SQRT_SEQ_TIMEOUT_EN to enable the WAIT watchdog
// (rsp_timeout is tied low otherwise).
module sqrt_job_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_data,
  input  logic [TAG_W-1:0] req_tag,
  output logic             sq_start,
  output logic [31:0]      sq_in,
  input  logic [31:0]      sq_out,
  input  logic             sq_error,
  input  logic             sq_done,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_error,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_timeout
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_param_check
    $error("sqrt_job_sequencer: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  logic [31:0]      r_mem_data [DEPTH];
  logic [TAG_W-1:0] r_mem_tag  [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  state_t           r_state;
  logic             r_sq_start;
  logic [31:0]      r_sq_in;
  logic [TAG_W-1:0] r_hold_tag;
  logic             r_rsp_valid;
  logic [31:0]      r_rsp_data;
  logic             r_rsp_error;
  logic [TAG_W-1:0] r_rsp_tag;

`ifdef SQRT_SEQ_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]    r_timer;
  logic             r_rsp_timeout;
`endif

  logic w_full;
  logic w_push;
  logic w_pop;

  // No bypass: a pop in the same cycle does not open a slot while full.
  assign w_full = (r_count == CW'(DEPTH));
  assign w_push = req_valid & ~w_full;
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= req_data;
      r_mem_tag[r_wr_ptr]  <= req_tag;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // Job sequencer: pop, pulse start, wait for done, hold response until taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_sq_start  <= 1'b0;
      r_sq_in     <= '0;
      r_hold_tag  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_error <= 1'b0;
      r_rsp_tag   <= '0;
`ifdef SQRT_SEQ_TIMEOUT_EN
      r_timer       <= '0;
      r_rsp_timeout <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_sq_in    <= r_mem_data[r_rd_ptr];
            r_hold_tag <= r_mem_tag[r_rd_ptr];
            r_sq_start <= 1'b1;
            r_state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_sq_start <= 1'b0;
          r_state    <= S_WAIT;
`ifdef SQRT_SEQ_TIMEOUT_EN
          r_timer    <= '0;
`endif
        end
        S_WAIT: begin
          if (sq_done) begin
            r_rsp_data  <= sq_error ? '0 : sq_out;
            r_rsp_error <= sq_error;
            r_rsp_tag   <= r_hold_tag;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
`ifdef SQRT_SEQ_TIMEOUT_EN
            r_rsp_timeout <= 1'b0;
          end else if (r_timer == TW'(TIMEOUT - 1)) begin
            r_rsp_data    <= '0;
            r_rsp_error   <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_tag     <= r_hold_tag;
            r_rsp_valid   <= 1'b1;
            r_state       <= S_RESP;
          end else begin
            r_timer <= r_timer + TW'(1);
`endif
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_ready = ~w_full;
  assign sq_start  = r_sq_start;
  assign sq_in     = r_sq_in;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_error = r_rsp_error;
  assign rsp_tag   = r_rsp_tag;
`ifdef SQRT_SEQ_TIMEOUT_EN
  assign rsp_timeout = r_rsp_timeout;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_sqrt_job_sequencer.sv
// Testbench for sqrt_job_sequencer: behavioural sqrt core stub plus a
// queue/arithmetic reference for responses. SQRT_SEQ_TIMEOUT_EN adds the
// watchdog scenario.
module tb_sqrt_job_sequencer;
  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_data = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             sq_start;
  logic [31:0]      sq_in;
  logic [31:0]      sq_out;
  logic             sq_error;
  logic             sq_done;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_data;
  logic             rsp_error;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_timeout;

  int n_asserts = 0;
  int n_fails   = 0;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             err;
  } rsp_t;

  sqrt_job_sequencer #(.DEPTH(4), .TAG_W(TAG_W), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_tag(req_tag),
    .sq_start(sq_start), .sq_in(sq_in), .sq_out(sq_out), .sq_error(sq_error), .sq_done(sq_done),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout)
  );

  always #5 clk = ~clk;

  // Core stub root: binary search on 64-bit products.
  function automatic logic [31:0] core_root(input logic [31:0] x);
    longint unsigned lo = 0, hi = 65536, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mid * mid <= longint'(x)) lo = mid; else hi = mid;
    end
    return 32'(lo);
  endfunction

  // Reference root from real arithmetic.
  function automatic logic [31:0] ref_root(input logic [31:0] x);
    return 32'($rtoi($floor($sqrt(real'(x)))));
  endfunction

  // Core stub: samples start on the falling edge; negative -> done/error at once,
  // legal -> done low for 11 falling edges, then result.
  int   c_cnt  = 0;
  bit   c_hang = 1'b0;
  logic [31:0] c_op = '0;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_done <= 1'b0; sq_error <= 1'b0; sq_out <= '0; c_cnt <= 0;
    end else if (sq_start) begin
      if (sq_in[31]) begin
        sq_error <= 1'b1; sq_done <= 1'b1; sq_out <= '0; c_cnt <= 0;
      end else begin
        sq_error <= 1'b0; sq_done <= 1'b0; c_op <= sq_in; c_cnt <= c_hang ? 0 : 11;
      end
    end else if (c_cnt > 0) begin
      c_cnt <= c_cnt - 1;
      if (c_cnt == 1) begin
        sq_done <= 1'b1;
        sq_out  <= core_root(c_op);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL global_watchdog: simulation did not complete, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  // One job into an idle sequencer with rsp_ready=1; checks start pulse,
  // response latency and payload.
  task automatic single_job(input string nm, input logic [31:0] d, input logic [TAG_W-1:0] t,
                            input int exp_cyc, input bit exp_to);
    int k;
    logic exp_err;
    exp_err = d[31] | exp_to;
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_data = d; req_tag = t;
    check({nm, "_req_ready"}, 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    k = 0;
    while (!rsp_valid && k < 200) begin
      tick();
      k++;
      if (k == 1) begin
        check({nm, "_start_E1"}, 64'(sq_start), 64'd1);
        check({nm, "_sq_in"}, 64'(sq_in), 64'(d));
      end
      if (k == 2) check({nm, "_start_E2"}, 64'(sq_start), 64'd0);
    end
    check({nm, "_latency"}, 64'(k), 64'(exp_cyc));
    check({nm, "_data"}, 64'(rsp_data), exp_err ? 64'd0 : 64'(ref_root(d)));
    check({nm, "_error"}, 64'(rsp_error), 64'(exp_err));
    check({nm, "_tag"}, 64'(rsp_tag), 64'(t));
    check({nm, "_timeout"}, 64'(rsp_timeout), 64'(exp_to));
    tick();
    check({nm, "_valid_drop"}, 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [31:0] ops [6];
    rsp_t q[$];
    rsp_t e;
    int k, got, r0, r1, bad, n;
    logic prev_v, hs_req, hs_rsp;
    logic [31:0] cap_d;
    logic [TAG_W-1:0] cap_t;
    logic cap_e;

    // Reset state
    #1;
    check("reset_ctl", {63'd0, req_ready}, 64'd1);
    check("reset_out", {sq_start, sq_in, rsp_valid, rsp_error, rsp_tag, rsp_timeout},
          64'd0);
    check("reset_rsp_data", 64'(rsp_data), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Legal and negative single jobs
    single_job("sqrt16", 32'd16, 4'd3, 13, 1'b0);
    single_job("neg", 32'h8000_0000, 4'd5, 3, 1'b0);

    // Back-to-back fill with rsp_ready held low
    ops = '{32'd100, 32'd144, 32'd9, 32'd81, 32'd49, 32'd25};
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_data = ops[i]; req_tag = TAG_W'(i);
      check($sformatf("b2b_ready_%0d", i), 64'(req_ready), 64'd1);
      tick();
    end
    req_data = ops[5]; req_tag = TAG_W'(5);
    check("b2b_full", 64'(req_ready), 64'd0);
    k = 0;
    while (!rsp_valid && k < 50) begin tick(); k++; end
    check("b2b_first_rsp", 64'(rsp_valid), 64'd1);
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("resp_hold_%0d", j),
            64'({rsp_valid, rsp_error, rsp_tag, rsp_data, sq_start, req_ready}),
            64'({1'b1, 1'b0, 4'd0, 32'd10, 1'b0, 1'b0}));
    end
    rsp_ready = 1'b1;
    got = 0; k = 0;
    while (got < 6 && k < 300) begin
      hs_req = req_valid & req_ready;
      hs_rsp = rsp_valid & rsp_ready;
      cap_d = rsp_data; cap_t = rsp_tag; cap_e = rsp_error;
      tick(); k++;
      if (hs_req) req_valid = 1'b0;
      if (hs_rsp) begin
        check($sformatf("b2b_data_%0d", got), 64'(cap_d), 64'(ref_root(ops[got])));
        check($sformatf("b2b_tag_%0d", got), 64'({cap_e, cap_t}), 64'(got));
        got++;
      end
    end
    check("b2b_count", 64'(got), 64'd6);
    req_valid = 1'b0;
    tick();

    // Minimum response spacing for negative operands
    req_valid = 1'b1; req_data = 32'hFFFF_FFF0; req_tag = 4'd8;
    tick();
    req_data = 32'h9000_0001; req_tag = 4'd9;
    tick();
    req_valid = 1'b0;
    r0 = -1; r1 = -1; prev_v = rsp_valid;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (rsp_valid && !prev_v) begin
        if (r0 < 0) r0 = c; else if (r1 < 0) r1 = c;
      end
      prev_v = rsp_valid;
    end
    check("neg_gap", 64'(r1 - r0), 64'd4);

    // Reset mid-WAIT with two entries queued
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_data = 32'd100; req_tag = 4'd1; tick();
    req_data = 32'd4; req_tag = 4'd2; tick();
    req_data = 32'd9; req_tag = 4'd3; tick();
    req_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    check("midrst_ctl", {63'd0, req_ready}, 64'd1);
    check("midrst_out", {sq_start, sq_in, rsp_valid, rsp_error, rsp_tag, rsp_timeout},
          64'd0);
    check("midrst_rsp_data", 64'(rsp_data), 64'd0);
    tick(); tick();
    rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (rsp_valid || sq_start) bad++;
    end
    check("midrst_quiet", 64'(bad), 64'd0);
    single_job("after_rst", 32'd49, 4'd7, 13, 1'b0);

    // Randomized bursts against the queue reference
    for (int b = 0; b < 15; b++) begin
      n = $urandom_range(1, 4);
      rsp_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0: req_data = {1'b1, 31'($urandom)};
          1: req_data = 32'($urandom_range(0, 255));
          2: begin k = $urandom_range(0, 46340); req_data = 32'(k * k); end
          default: req_data = $urandom & 32'h7FFF_FFFF;
        endcase
        req_tag = TAG_W'($urandom);
        req_valid = 1'b1;
        e.tag = req_tag; e.err = req_data[31];
        e.data = req_data[31] ? 32'd0 : ref_root(req_data);
        q.push_back(e);
        check($sformatf("rnd_ready_%0d_%0d", b, i), 64'(req_ready), 64'd1);
        tick();
      end
      req_valid = 1'b0;
      k = 0;
      while (q.size() != 0 && k < 60 * n) begin
        rsp_ready = 1'($urandom_range(0, 1));
        hs_rsp = rsp_valid & rsp_ready;
        cap_d = rsp_data; cap_t = rsp_tag; cap_e = rsp_error;
        tick(); k++;
        if (hs_rsp) begin
          e = q.pop_front();
          check($sformatf("rnd_rsp_%0d", b), 64'({cap_e, cap_t, cap_d}),
                64'({e.err, e.tag, e.data}));
        end
      end
      check($sformatf("rnd_drain_%0d", b), 64'(q.size()), 64'd0);
      q.delete();
      rsp_ready = 1'b1;
      tick();
    end

`ifdef SQRT_SEQ_TIMEOUT_EN
    // Watchdog: core never completes
    c_hang = 1'b1;
    single_job("timeout", 32'd100, 4'd6, 66, 1'b1);
    c_hang = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
